core_ctrl: RTL and testbench

Multi-cycle sequencer for the NPC core. It steps each instruction through fetch, execute, optional memory access and write-back, and holds the IFU, instruction latch, LSU, PC register and register file to one action per phase. It generates `pc_w_en` and `reg_w_en`, which makes those write enables a function of sequencing state rather than of decode alone. It also keeps cycle and retired-instruction counters and enters a sticky halt state on `ebreak` or an error.

---
 rtl/core_ctrl_pkg.sv | 43 ++++
 rtl/ctrl_counter.sv | 31 +++
 rtl/core_ctrl.sv | 171 +++++++++++++++++
 tb/tb_core_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the NPC core sequencer: FSM states, instruction types and decode helpers.
// The optional handshake timeout in core_ctrl is enabled by defining CORE_CTRL_TIMEOUT_EN.
package core_ctrl_pkg;

  localparam int CTRL_STATE_WIDTH = 3;
  localparam int INST_TYPE_WIDTH  = 3;

  typedef enum logic [CTRL_STATE_WIDTH-1:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4,
    ST_ERR   = 3'd5
  } ctrl_state_e;

  localparam logic [INST_TYPE_WIDTH-1:0] INST_R = 3'd0;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_I = 3'd1;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_S = 3'd2;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_B = 3'd3;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_U = 3'd4;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_J = 3'd5;

  function automatic logic inst_type_legal(input logic [INST_TYPE_WIDTH-1:0] t);
    logic ok;
    case (t)
      INST_R, INST_I, INST_S, INST_B, INST_U, INST_J: ok = 1'b1;
      default:                                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // S and B formats carry no destination register.
  function automatic logic inst_writes_rd(input logic [INST_TYPE_WIDTH-1:0] t);
    logic wr;
    case (t)
      INST_R, INST_I, INST_U, INST_J: wr = 1'b1;
      default:                        wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/ctrl_counter.sv
// Free-running performance counter with enable and synchronous clear; wraps silently.
module ctrl_counter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer with sticky halt/error and cycle/instret counters.
// Define CORE_CTRL_TIMEOUT_EN to fault after TIMEOUT_CYCLES consecutive not-ready wait cycles.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INST_TYPE_WIDTH-1:0]  inst_type,
  input  logic                        is_load,
  input  logic                        is_store,
  input  logic                        is_ebreak,
  output logic                        ifu_req,
  input  logic                        ifu_ready,
  output logic                        inst_latch_en,
  output logic                        lsu_req,
  output logic                        lsu_we,
  input  logic                        lsu_ready,
  output logic                        pc_w_en,
  output logic                        reg_w_en,
  output logic                        halt,
  output logic                        error,
  output logic [CTRL_STATE_WIDTH-1:0] state,
  output logic [CNT_WIDTH-1:0]        cycle_cnt,
  output logic [CNT_WIDTH-1:0]        instret_cnt
);

  ctrl_state_e state_q;
  ctrl_state_e state_d;

  logic ifu_req_s;
  logic lsu_req_s;
  logic lsu_we_s;
  logic pc_w_en_s;
  logic reg_w_en_s;
  logic halt_s;
  logic error_s;
  logic wait_expired_s;

  logic [CNT_WIDTH-1:0] cycle_cnt_s;
  logic [CNT_WIDTH-1:0] instret_cnt_s;

`ifdef CORE_CTRL_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;

  // Count consecutive not-ready cycles; any handshake or state change restarts the count.
  always_comb begin
    wait_cnt_d     = '0;
    wait_expired_s = 1'b0;
    if ((state_q == ST_FETCH && !ifu_ready) || (state_q == ST_MEM && !lsu_ready)) begin
      wait_expired_s = (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));
      wait_cnt_d     = wait_cnt_q + WAIT_W'(1);
    end else begin
      wait_cnt_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign wait_expired_s = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ifu_req_s  = 1'b0;
    lsu_req_s  = 1'b0;
    lsu_we_s   = 1'b0;
    pc_w_en_s  = 1'b0;
    reg_w_en_s = 1'b0;
    halt_s     = 1'b0;
    error_s    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ifu_req_s = 1'b1;
        if (ifu_ready) begin
          state_d = ST_EXEC;
        end else if (wait_expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (is_ebreak) begin
          state_d = ST_HALT;
        end else if (!inst_type_legal(inst_type)) begin
          state_d = ST_ERR;
        end else if (is_load || is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        lsu_req_s = 1'b1;
        lsu_we_s  = is_store;
        if (lsu_ready) begin
          state_d = ST_WB;
        end else if (wait_expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        pc_w_en_s  = 1'b1;
        reg_w_en_s = inst_writes_rd(inst_type);
        state_d    = ST_FETCH;
      end
      ST_HALT: begin
        halt_s  = 1'b1;
        state_d = ST_HALT;
      end
      ST_ERR: begin
        error_s = 1'b1;
        state_d = ST_ERR;
      end
      // Unused encodings are treated as a fault.
      default: begin
        state_d = ST_ERR;
      end
    endcase
  end

  ctrl_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk (clk),
    .clr (rst),
    .en  (state_q != ST_HALT && state_q != ST_ERR),
    .cnt (cycle_cnt_s)
  );

  ctrl_counter #(.WIDTH(CNT_WIDTH)) u_instret_cnt (
    .clk (clk),
    .clr (rst),
    .en  (state_q == ST_WB),
    .cnt (instret_cnt_s)
  );

  // Reset masks every output so no partial write-back escapes a mid-instruction reset.
  assign ifu_req       = ifu_req_s & ~rst;
  assign inst_latch_en = ifu_req & ifu_ready;
  assign lsu_req       = lsu_req_s & ~rst;
  assign lsu_we        = lsu_we_s & ~rst;
  assign pc_w_en       = pc_w_en_s & ~rst;
  assign reg_w_en      = reg_w_en_s & ~rst;
  assign halt          = halt_s & ~rst;
  assign error         = error_s & ~rst;
  assign state         = rst ? '0 : state_q;
  assign cycle_cnt     = rst ? '0 : cycle_cnt_s;
  assign instret_cnt   = rst ? '0 : instret_cnt_s;

endmodule

// File: tb/tb_core_ctrl.sv
// Scoreboard bench for core_ctrl: each scenario queues per-cycle expectations and checks them as cycles run.
// The timeout scenario changes with CORE_CTRL_TIMEOUT_EN (TIMEOUT_CYCLES = 4 here).
module tb_core_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  inst_type = 3'd0;
  logic        is_load = 1'b0, is_store = 1'b0, is_ebreak = 1'b0;
  logic        ifu_ready = 1'b0, lsu_ready = 1'b0;
  logic        ifu_req, inst_latch_en, lsu_req, lsu_we, pc_w_en, reg_w_en, halt, error;
  logic [2:0]  state;
  logic [63:0] cycle_cnt, instret_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  core_ctrl #(.CNT_WIDTH(64), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .inst_type(inst_type), .is_load(is_load), .is_store(is_store),
    .is_ebreak(is_ebreak), .ifu_req(ifu_req), .ifu_ready(ifu_ready), .inst_latch_en(inst_latch_en),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_ready(lsu_ready), .pc_w_en(pc_w_en),
    .reg_w_en(reg_w_en), .halt(halt), .error(error), .state(state),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  // Observed vector: {state[2:0], ifu_req, inst_latch_en, lsu_req, lsu_we, pc_w_en, reg_w_en, halt, error}
  localparam logic [10:0] V_ZERO  = 11'b000_0000_0000;
  localparam logic [10:0] V_FETCH = 11'b000_1000_0000;
  localparam logic [10:0] V_LATCH = 11'b000_1100_0000;
  localparam logic [10:0] V_EXEC  = 11'b001_0000_0000;
  localparam logic [10:0] V_MEM   = 11'b010_0010_0000;
  localparam logic [10:0] V_MEMW  = 11'b010_0011_0000;
  localparam logic [10:0] V_WB    = 11'b011_0000_1000;
  localparam logic [10:0] V_WBR   = 11'b011_0000_1100;
  localparam logic [10:0] V_HALT  = 11'b100_0000_0010;
  localparam logic [10:0] V_ERR   = 11'b101_0000_0001;

  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_U = 3'd4, T_J = 3'd5, T_BAD = 3'd6;

  typedef struct packed {
    logic       r, ir, lr;
    logic [2:0] it;
    logic       ld, st, eb;
  } stim_t;

  typedef struct packed {
    logic [10:0] v;
    logic        chk;
    logic [63:0] cyc, ret;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];

  function automatic stim_t mk(logic r, logic ir, logic lr, logic [2:0] it, logic ld, logic st, logic eb);
    stim_t s;
    s = '{r: r, ir: ir, lr: lr, it: it, ld: ld, st: st, eb: eb};
    return s;
  endfunction

  task automatic add(input stim_t s, input logic [10:0] v);
    stim_q.push_back(s);
    exp_q.push_back('{v: v, chk: 1'b0, cyc: 64'd0, ret: 64'd0});
  endtask

  task automatic add_c(input stim_t s, input logic [10:0] v, input logic [63:0] cyc, input logic [63:0] ret);
    stim_q.push_back(s);
    exp_q.push_back('{v: v, chk: 1'b1, cyc: cyc, ret: ret});
  endtask

  task automatic drive(input stim_t s);
    @(negedge clk);
    rst = s.r; ifu_ready = s.ir; lsu_ready = s.lr;
    inst_type = s.it; is_load = s.ld; is_store = s.st; is_ebreak = s.eb;
    #1;
  endtask

  function automatic logic [10:0] observe();
    return {state, ifu_req, inst_latch_en, lsu_req, lsu_we, pc_w_en, reg_w_en, halt, error};
  endfunction

  task automatic test_reset();
    exp_t e;
    add(mk(1, 1, 1, T_I, 0, 0, 0), V_ZERO);
    add_c(mk(1, 1, 1, T_I, 0, 0, 0), V_ZERO, 64'd0, 64'd0);
    add_c(mk(0, 0, 0, T_I, 0, 0, 0), V_FETCH, 64'd0, 64'd0);
    add_c(mk(0, 0, 0, T_I, 0, 0, 0), V_FETCH, 64'd1, 64'd0);
    for (int i = 0; i < stim_q.size(); i++) begin
      drive(stim_q[i]);
      e = exp_q.pop_front();
      n_assert++;
      if (observe() !== e.v) begin
        n_fail++; $display("FAIL reset step %0d: outputs %b, expected %b", i, observe(), e.v);
      end
      if (e.chk) begin
        n_assert++;
        if (cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
          n_fail++; $display("FAIL reset_cnt step %0d: cyc/ret %0d/%0d, expected %0d/%0d", i, cycle_cnt, instret_cnt, e.cyc, e.ret);
        end
      end
    end
    stim_q.delete();
  endtask

  task automatic test_alu();
    exp_t e;
    add(mk(1, 1, 0, T_I, 0, 0, 0), V_ZERO);
    for (int k = 0; k < 3; k++) begin
      add(mk(0, 1, 0, T_I, 0, 0, 0), V_LATCH);
      add(mk(0, 1, 0, T_I, 0, 0, 0), V_EXEC);
      add(mk(0, 1, 0, T_I, 0, 0, 0), V_WBR);
    end
    add_c(mk(0, 1, 0, T_I, 0, 0, 0), V_LATCH, 64'd9, 64'd3);
    for (int i = 0; i < stim_q.size(); i++) begin
      drive(stim_q[i]);
      e = exp_q.pop_front();
      n_assert++;
      if (observe() !== e.v) begin
        n_fail++; $display("FAIL alu step %0d: outputs %b, expected %b", i, observe(), e.v);
      end
      if (e.chk) begin
        n_assert++;
        if (cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
          n_fail++; $display("FAIL alu_cnt step %0d: cyc/ret %0d/%0d, expected %0d/%0d", i, cycle_cnt, instret_cnt, e.cyc, e.ret);
        end
      end
    end
    stim_q.delete();
  endtask

  task automatic test_load();
    exp_t e;
    add(mk(1, 0, 0, T_I, 1, 0, 0), V_ZERO);
    add(mk(0, 1, 0, T_I, 1, 0, 0), V_LATCH);
    add(mk(0, 1, 1, T_I, 1, 0, 0), V_EXEC);
    add(mk(0, 1, 0, T_I, 1, 0, 0), V_MEM);
    add(mk(0, 1, 0, T_I, 1, 0, 0), V_MEM);
    add(mk(0, 1, 1, T_I, 1, 0, 0), V_MEM);
    add(mk(0, 0, 1, T_I, 1, 0, 0), V_WBR);
    add_c(mk(0, 0, 0, T_I, 0, 0, 0), V_FETCH, 64'd6, 64'd1);
    for (int i = 0; i < stim_q.size(); i++) begin
      drive(stim_q[i]);
      e = exp_q.pop_front();
      n_assert++;
      if (observe() !== e.v) begin
        n_fail++; $display("FAIL load step %0d: outputs %b, expected %b", i, observe(), e.v);
      end
      if (e.chk) begin
        n_assert++;
        if (cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
          n_fail++; $display("FAIL load_cnt step %0d: cyc/ret %0d/%0d, expected %0d/%0d", i, cycle_cnt, instret_cnt, e.cyc, e.ret);
        end
      end
    end
    stim_q.delete();
  endtask

  task automatic test_store_branch();
    exp_t e;
    add(mk(1, 0, 0, T_S, 0, 1, 0), V_ZERO);
    add(mk(0, 1, 0, T_S, 0, 1, 0), V_LATCH);
    add(mk(0, 0, 0, T_S, 0, 1, 0), V_EXEC);
    add(mk(0, 0, 1, T_S, 0, 1, 0), V_MEMW);
    add(mk(0, 0, 0, T_S, 0, 1, 0), V_WB);
    add(mk(0, 1, 0, T_B, 0, 0, 0), V_LATCH);
    add(mk(0, 0, 1, T_B, 0, 0, 0), V_EXEC);
    add(mk(0, 0, 0, T_B, 0, 0, 0), V_WB);
    add_c(mk(0, 0, 0, T_B, 0, 0, 0), V_FETCH, 64'd7, 64'd2);
    for (int i = 0; i < stim_q.size(); i++) begin
      drive(stim_q[i]);
      e = exp_q.pop_front();
      n_assert++;
      if (observe() !== e.v) begin
        n_fail++; $display("FAIL store_branch step %0d: outputs %b, expected %b", i, observe(), e.v);
      end
      if (e.chk) begin
        n_assert++;
        if (cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
          n_fail++; $display("FAIL store_branch_cnt step %0d: cyc/ret %0d/%0d, expected %0d/%0d", i, cycle_cnt, instret_cnt, e.cyc, e.ret);
        end
      end
    end
    stim_q.delete();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [2:0] types [3];
    types = '{T_R, T_U, T_J};
    add(mk(1, 0, 0, T_R, 0, 0, 0), V_ZERO);
    add(mk(0, 0, 0, T_R, 0, 0, 0), V_FETCH);
    add(mk(0, 0, 0, T_R, 0, 0, 0), V_FETCH);
    for (int k = 0; k < 3; k++) begin
      add(mk(0, 1, 0, types[k], 0, 0, 0), V_LATCH);
      add(mk(0, 0, 0, types[k], 0, 0, 0), V_EXEC);
      add(mk(0, 0, 0, types[k], 0, 0, 0), V_WBR);
    end
    add_c(mk(0, 0, 0, T_R, 0, 0, 0), V_FETCH, 64'd11, 64'd3);
    for (int i = 0; i < stim_q.size(); i++) begin
      drive(stim_q[i]);
      e = exp_q.pop_front();
      n_assert++;
      if (observe() !== e.v) begin
        n_fail++; $display("FAIL back_to_back step %0d: outputs %b, expected %b", i, observe(), e.v);
      end
      if (e.chk) begin
        n_assert++;
        if (cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
          n_fail++; $display("FAIL back_to_back_cnt step %0d: cyc/ret %0d/%0d, expected %0d/%0d", i, cycle_cnt, instret_cnt, e.cyc, e.ret);
        end
      end
    end
    stim_q.delete();
  endtask

  task automatic test_ebreak();
    exp_t e;
    add(mk(1, 0, 0, T_I, 1, 0, 1), V_ZERO);
    add(mk(0, 1, 0, T_I, 1, 0, 1), V_LATCH);
    add(mk(0, 1, 1, T_I, 1, 0, 1), V_EXEC);
    for (int k = 0; k < 99; k++) add(mk(0, 1, 1, T_I, 1, 0, 1), V_HALT);
    add_c(mk(0, 1, 1, T_I, 1, 0, 1), V_HALT, 64'd2, 64'd0);
    add_c(mk(1, 1, 1, T_I, 0, 0, 0), V_ZERO, 64'd0, 64'd0);
    add_c(mk(0, 0, 0, T_I, 0, 0, 0), V_FETCH, 64'd0, 64'd0);
    for (int i = 0; i < stim_q.size(); i++) begin
      drive(stim_q[i]);
      e = exp_q.pop_front();
      n_assert++;
      if (observe() !== e.v) begin
        n_fail++; $display("FAIL ebreak step %0d: outputs %b, expected %b", i, observe(), e.v);
      end
      if (e.chk) begin
        n_assert++;
        if (cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
          n_fail++; $display("FAIL ebreak_cnt step %0d: cyc/ret %0d/%0d, expected %0d/%0d", i, cycle_cnt, instret_cnt, e.cyc, e.ret);
        end
      end
    end
    stim_q.delete();
  endtask

  task automatic test_illegal_and_reset();
    exp_t e;
    add(mk(1, 0, 0, T_BAD, 1, 0, 0), V_ZERO);
    add(mk(0, 1, 0, T_BAD, 1, 0, 0), V_LATCH);
    add(mk(0, 1, 1, T_BAD, 1, 0, 0), V_EXEC);
    add(mk(0, 1, 1, T_BAD, 1, 0, 0), V_ERR);
    add_c(mk(0, 1, 1, T_I, 0, 0, 0), V_ERR, 64'd2, 64'd0);
    add(mk(1, 1, 1, T_I, 0, 0, 0), V_ZERO);
    add_c(mk(0, 1, 0, T_I, 1, 0, 0), V_LATCH, 64'd0, 64'd0);
    add(mk(0, 0, 0, T_I, 1, 0, 0), V_EXEC);
    add(mk(0, 0, 0, T_I, 1, 0, 0), V_MEM);
    add(mk(1, 0, 1, T_I, 1, 0, 0), V_ZERO);
    add_c(mk(0, 0, 0, T_I, 0, 0, 0), V_FETCH, 64'd0, 64'd0);
    for (int i = 0; i < stim_q.size(); i++) begin
      drive(stim_q[i]);
      e = exp_q.pop_front();
      n_assert++;
      if (observe() !== e.v) begin
        n_fail++; $display("FAIL illegal_reset step %0d: outputs %b, expected %b", i, observe(), e.v);
      end
      if (e.chk) begin
        n_assert++;
        if (cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
          n_fail++; $display("FAIL illegal_reset_cnt step %0d: cyc/ret %0d/%0d, expected %0d/%0d", i, cycle_cnt, instret_cnt, e.cyc, e.ret);
        end
      end
    end
    stim_q.delete();
  endtask

  task automatic test_timeout();
    exp_t e;
`ifdef CORE_CTRL_TIMEOUT_EN
    add(mk(1, 0, 0, T_I, 0, 0, 0), V_ZERO);
    for (int k = 0; k < 4; k++) add(mk(0, 0, 0, T_I, 0, 0, 0), V_FETCH);
    add_c(mk(0, 0, 0, T_I, 0, 0, 0), V_ERR, 64'd4, 64'd0);
    add(mk(1, 0, 0, T_I, 0, 0, 0), V_ZERO);
    for (int k = 0; k < 3; k++) add(mk(0, 0, 0, T_I, 0, 0, 0), V_FETCH);
    add(mk(0, 1, 0, T_I, 1, 0, 0), V_LATCH);
    add(mk(0, 0, 0, T_I, 1, 0, 0), V_EXEC);
    for (int k = 0; k < 4; k++) add(mk(0, 0, 0, T_I, 1, 0, 0), V_MEM);
    add(mk(0, 0, 0, T_I, 1, 0, 0), V_ERR);
    add(mk(1, 0, 0, T_I, 1, 0, 0), V_ZERO);
    add(mk(0, 1, 0, T_I, 1, 0, 0), V_LATCH);
    add(mk(0, 0, 0, T_I, 1, 0, 0), V_EXEC);
    for (int k = 0; k < 3; k++) add(mk(0, 0, 0, T_I, 1, 0, 0), V_MEM);
    add(mk(0, 0, 1, T_I, 1, 0, 0), V_MEM);
    add_c(mk(0, 0, 0, T_I, 1, 0, 0), V_WBR, 64'd6, 64'd0);
`else
    add(mk(1, 0, 0, T_I, 0, 0, 0), V_ZERO);
    for (int k = 0; k < 12; k++) add(mk(0, 0, 0, T_I, 1, 0, 0), V_FETCH);
    add(mk(0, 1, 0, T_I, 1, 0, 0), V_LATCH);
    add(mk(0, 0, 0, T_I, 1, 0, 0), V_EXEC);
    for (int k = 0; k < 12; k++) add(mk(0, 0, 0, T_I, 1, 0, 0), V_MEM);
    add(mk(0, 0, 1, T_I, 1, 0, 0), V_MEM);
    add_c(mk(0, 0, 0, T_I, 1, 0, 0), V_WBR, 64'd27, 64'd0);
`endif
    for (int i = 0; i < stim_q.size(); i++) begin
      drive(stim_q[i]);
      e = exp_q.pop_front();
      n_assert++;
      if (observe() !== e.v) begin
        n_fail++; $display("FAIL timeout step %0d: outputs %b, expected %b", i, observe(), e.v);
      end
      if (e.chk) begin
        n_assert++;
        if (cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
          n_fail++; $display("FAIL timeout_cnt step %0d: cyc/ret %0d/%0d, expected %0d/%0d", i, cycle_cnt, instret_cnt, e.cyc, e.ret);
        end
      end
    end
    stim_q.delete();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store_branch();
    test_back_to_back();
    test_ebreak();
    test_illegal_and_reset();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
